// File: rtl/corr_search_sched.sv
// Correlation search scheduler: sweeps candidate start positions in raster order,
// runs one engine correlation per position and tracks the best score and its coordinate.
// Optional feature macro: CORR_SCHED_THRESH_EN (early stop when score >= iThreshold).
module corr_search_sched #(
   parameter int unsigned COORD_W = 13,
   parameter int unsigned SCORE_W = 32,
   parameter int unsigned X_MIN   = 0,
   parameter int unsigned X_MAX   = 639,
   parameter int unsigned Y_MIN   = 0,
   parameter int unsigned Y_MAX   = 479,
   parameter int unsigned STEP    = 8
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               iStart,
   input  logic               iAbort,
   output logic               oCorrReady,
   output logic [COORD_W-1:0] oXstart,
   output logic [COORD_W-1:0] oYstart,
   input  logic               iCorrFinished,
   input  logic [SCORE_W-1:0] iCorrScore,
   output logic               oBusy,
   output logic               oDone,
   output logic [SCORE_W-1:0] oBestScore,
   output logic [COORD_W-1:0] oBestX,
   output logic [COORD_W-1:0] oBestY,
`ifdef CORR_SCHED_THRESH_EN
   input  logic [SCORE_W-1:0] iThreshold,
   output logic               oHit,
`endif
   output logic [15:0]        oPosCount
);

   localparam int unsigned CW1 = COORD_W + 1;

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StCapture, StFinish} state_e;

   state_e               state_q, state_d;
   logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0]   best_x_q, best_x_d, best_y_q, best_y_d;
   logic [SCORE_W-1:0]   best_score_q, best_score_d;
   logic [15:0]          pos_cnt_q, pos_cnt_d;
   logic                 best_vld_q, best_vld_d;
   logic                 hit_now;
   logic [CW1-1:0]       x_next, y_next;
   logic                 x_adv_ok, y_adv_ok, take_best;

   // One extra bit so the advance compare never wraps near the top of the coordinate range.
   assign x_next   = {1'b0, x_q} + CW1'(STEP);
   assign y_next   = {1'b0, y_q} + CW1'(STEP);
   assign x_adv_ok = (x_next <= CW1'(X_MAX));
   assign y_adv_ok = (y_next <= CW1'(Y_MAX));

`ifdef CORR_SCHED_THRESH_EN
   logic hit_q, hit_d;
   assign hit_now = (iCorrScore >= iThreshold);
   assign oHit    = hit_q;
`else
   assign hit_now = 1'b0;
`endif

   // Strict compare keeps the earliest position on ties; a threshold hit always records.
   assign take_best = !best_vld_q || (iCorrScore > best_score_q) || hit_now;

   // Next-state and datapath update; abort overrides everything and freezes all results.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      best_x_d     = best_x_q;
      best_y_d     = best_y_q;
      best_score_d = best_score_q;
      pos_cnt_d    = pos_cnt_q;
      best_vld_d   = best_vld_q;
`ifdef CORR_SCHED_THRESH_EN
      hit_d        = hit_q;
`endif
      if (iAbort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (iStart) state_d = StLoad;
            end
            StLoad: begin
               x_d          = COORD_W'(X_MIN);
               y_d          = COORD_W'(Y_MIN);
               pos_cnt_d    = '0;
               best_vld_d   = 1'b0;
               best_score_d = '0;
               best_x_d     = '0;
               best_y_d     = '0;
`ifdef CORR_SCHED_THRESH_EN
               hit_d        = 1'b0;
`endif
               state_d      = StRun;
            end
            StRun: begin
               if (iCorrFinished) state_d = StCapture;
            end
            StCapture: begin
               pos_cnt_d = pos_cnt_q + 16'd1;
               if (take_best) begin
                  best_vld_d   = 1'b1;
                  best_score_d = iCorrScore;
                  best_x_d     = x_q;
                  best_y_d     = y_q;
               end
               if (hit_now) begin
`ifdef CORR_SCHED_THRESH_EN
                  hit_d   = 1'b1;
`endif
                  state_d = StFinish;
               end else if (x_adv_ok) begin
                  x_d     = x_next[COORD_W-1:0];
                  state_d = StRun;
               end else if (y_adv_ok) begin
                  x_d     = COORD_W'(X_MIN);
                  y_d     = y_next[COORD_W-1:0];
                  state_d = StRun;
               end else begin
                  state_d = StFinish;
               end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q      <= StIdle;
         x_q          <= '0;
         y_q          <= '0;
         best_x_q     <= '0;
         best_y_q     <= '0;
         best_score_q <= '0;
         pos_cnt_q    <= '0;
         best_vld_q   <= 1'b0;
`ifdef CORR_SCHED_THRESH_EN
         hit_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         best_x_q     <= best_x_d;
         best_y_q     <= best_y_d;
         best_score_q <= best_score_d;
         pos_cnt_q    <= pos_cnt_d;
         best_vld_q   <= best_vld_d;
`ifdef CORR_SCHED_THRESH_EN
         hit_q        <= hit_d;
`endif
      end
   end

   assign oCorrReady = (state_q == StRun);
   assign oBusy      = (state_q != StIdle);
   assign oDone      = (state_q == StFinish);
   assign oXstart    = x_q;
   assign oYstart    = y_q;
   assign oBestScore = best_score_q;
   assign oBestX     = best_x_q;
   assign oBestY     = best_y_q;
   assign oPosCount  = pos_cnt_q;

endmodule

// File: tb/tb_corr_search_sched.sv
// Bench for corr_search_sched: behavioural engine model with random latency and a
// loop-based reference model of the raster sweep, best-score and threshold rules.
module tb_corr_search_sched;

   localparam int X_MIN = 0;
   localparam int X_MAX = 16;
   localparam int Y_MIN = 0;
   localparam int Y_MAX = 8;
   localparam int STEP  = 8;
`ifdef CORR_SCHED_THRESH_EN
   localparam bit THR = 1'b1;
`else
   localparam bit THR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start, abort, corr_ready, fin, busy, done;
   logic [12:0] xs, ys, bx, by;
   logic [31:0] score, bscore;
   logic [15:0] pcnt;
`ifdef CORR_SCHED_THRESH_EN
   logic [31:0] thr;
   logic        hit;
`endif

   corr_search_sched #(
      .COORD_W(13), .SCORE_W(32), .X_MIN(X_MIN), .X_MAX(X_MAX),
      .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .STEP(STEP)
   ) dut (
      .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iAbort(abort),
      .oCorrReady(corr_ready), .oXstart(xs), .oYstart(ys),
      .iCorrFinished(fin), .iCorrScore(score), .oBusy(busy), .oDone(done),
      .oBestScore(bscore), .oBestX(bx), .oBestY(by),
`ifdef CORR_SCHED_THRESH_EN
      .iThreshold(thr), .oHit(hit),
`endif
      .oPosCount(pcnt)
   );

   always #10 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          mode    = 0;
   logic [31:0] rtab [4][4];
   logic        eng_en  = 1'b0;
   logic        poke    = 1'b0;
   int          seen_x[$], seen_y[$];
   int          exp_cnt, exp_bx, exp_by;
   logic [31:0] exp_bs;
   logic        exp_hit;
   int          exp_x[$], exp_y[$];

   function automatic logic [31:0] score_of(int x, int y);
      case (mode)
         0:       return 32'(x + y);
         1:       return 32'd100;
         default: return rtab[(x / STEP) % 4][(y / STEP) % 4];
      endcase
   endfunction

   // Engine model: after a random 0..3 cycle run time, pulse finished with the score.
   initial begin
      int cnt;
      cnt   = 0;
      fin   = 1'b0;
      score = '0;
      forever begin
         @(negedge clk);
         if (eng_en && corr_ready) begin
            if (cnt == 0) begin
               fin   = 1'b1;
               score = score_of(int'(xs), int'(ys));
               seen_x.push_back(int'(xs));
               seen_y.push_back(int'(ys));
               cnt   = $urandom_range(0, 3);
            end else begin
               fin = 1'b0;
               cnt--;
            end
         end else begin
            fin = poke;
            cnt = $urandom_range(0, 3);
         end
      end
   end

   // Reference: enumerate raster positions, apply strict-greater best and threshold stop.
   task automatic model(input int limit, input logic [31:0] thr_v);
      bit          stop;
      bit          bv;
      logic [31:0] s;
      stop = 0; bv = 0;
      exp_cnt = 0; exp_bs = '0; exp_bx = 0; exp_by = 0; exp_hit = 1'b0;
      exp_x.delete(); exp_y.delete();
      for (int y = Y_MIN; y <= Y_MAX && !stop; y += STEP) begin
         for (int x = X_MIN; x <= X_MAX && !stop; x += STEP) begin
            if (exp_cnt == limit) begin
               stop = 1;
            end else begin
               s = score_of(x, y);
               exp_cnt++;
               exp_x.push_back(x);
               exp_y.push_back(y);
               if (!bv || s > exp_bs || (THR && s >= thr_v)) begin
                  bv = 1; exp_bs = s; exp_bx = x; exp_by = y;
               end
               if (THR && s >= thr_v) begin
                  exp_hit = 1'b1;
                  stop    = 1;
               end
            end
         end
      end
   endtask

   // Pulse start, then follow the sweep until idle; restart=1 re-pulses start while busy.
   task automatic run_sweep(input bit restart, output int dones, output int bad_busy,
                            output bit tmo);
      bit done_prev;
      dones = 0; bad_busy = 0; tmo = 1; done_prev = 0;
      seen_x.delete(); seen_y.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (done_prev && busy) bad_busy++;
         if (done) dones++;
         done_prev = done;
         if (!busy) begin
            tmo = 0;
            break;
         end
         start = restart && (i % 5 == 4);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; eng_en = 1'b1; poke = 1'b0; mode = 0;
`ifdef CORR_SCHED_THRESH_EN
      thr = '1;
`endif
      #5;
      n_tests++;
      if ({corr_ready, busy, done, xs, ys} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b x=%0d y=%0d, want all 0",
                  corr_ready, busy, done, xs, ys);
      end
      n_tests++;
      if ({bscore, bx, by, pcnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_best: got score=%0d x=%0d y=%0d cnt=%0d, want all 0",
                  bscore, bx, by, pcnt);
      end
`ifdef CORR_SCHED_THRESH_EN
      n_tests++;
      if (hit !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hit: got %b want 0", hit);
      end
`endif
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy got %b want 0", busy);
      end
   endtask

   // Checks shared by whole-sweep tests are written inline per test.
   task automatic test_raster();
      int dn, bb; bit tmo;
      mode = 0;
      model(1000, 32'hFFFF_FFFF);
      run_sweep(0, dn, bb, tmo);
      n_tests++;
      if (tmo || dn != 1 || bb != 0) begin
         n_fail++;
         $display("FAIL raster_done: tmo=%0d dones=%0d busy_after=%0d, want 0/1/0", tmo, dn, bb);
      end
      n_tests++;
      if (pcnt !== 16'(exp_cnt) || exp_cnt != 6) begin
         n_fail++;
         $display("FAIL raster_count: got %0d want %0d (6)", pcnt, exp_cnt);
      end
      n_tests++;
      if (bscore !== 32'd24 || bx !== 13'd16 || by !== 13'd8) begin
         n_fail++;
         $display("FAIL raster_best: got %0d@(%0d,%0d) want 24@(16,8)", bscore, bx, by);
      end
      n_tests++;
      if (seen_x != exp_x || seen_y != exp_y) begin
         n_fail++;
         $display("FAIL raster_order: got %0d positions want %0d in raster order",
                  seen_x.size(), exp_x.size());
      end
   endtask

   task automatic test_ties();
      int dn, bb; bit tmo;
      mode = 1;
      model(1000, 32'hFFFF_FFFF);
      run_sweep(0, dn, bb, tmo);
      n_tests++;
      if (tmo || bscore !== 32'd100 || bx !== 13'(X_MIN) || by !== 13'(Y_MIN)) begin
         n_fail++;
         $display("FAIL ties_best: got %0d@(%0d,%0d) want 100@(%0d,%0d)",
                  bscore, bx, by, X_MIN, Y_MIN);
      end
   endtask

   task automatic test_random();
      int dn, bb; bit tmo;
      mode = 2;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
               rtab[i][j] = $urandom & ((r == 3) ? 32'h7 : 32'h7FFF_FFFF);
         model(1000, 32'hFFFF_FFFF);
         run_sweep(0, dn, bb, tmo);
         n_tests++;
         if (tmo || dn != 1 || pcnt !== 16'(exp_cnt) || bscore !== exp_bs ||
             bx !== 13'(exp_bx) || by !== 13'(exp_by)) begin
            n_fail++;
            $display("FAIL random_sweep%0d: got cnt=%0d %0d@(%0d,%0d) dones=%0d want %0d %0d@(%0d,%0d)",
                     r, pcnt, bscore, bx, by, dn, exp_cnt, exp_bs, exp_bx, exp_by);
         end
      end
   endtask

   task automatic test_abort();
      int dones; bit seen3; logic [31:0] sc;
      mode = 2;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            rtab[i][j] = $urandom & 32'h7FFF_FFFF;
      model(3, 32'hFFFF_FFFF);
      dones = 0; seen3 = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done) dones++;
         if (pcnt == 16'd3) begin
            seen3 = 1;
            break;
         end
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      n_tests++;
      if (!seen3 || busy !== 1'b0 || dones != 0) begin
         n_fail++;
         $display("FAIL abort_idle: reached3=%0d busy=%b dones=%0d want 1/0/0", seen3, busy, dones);
      end
      sc = bscore;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      n_tests++;
      if (pcnt !== 16'd3 || bscore !== exp_bs || bx !== 13'(exp_bx) || by !== 13'(exp_by) ||
          dones != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_hold: got cnt=%0d %0d@(%0d,%0d) dones=%0d want 3 %0d@(%0d,%0d) 0",
                  pcnt, bscore, bx, by, dones, exp_bs, exp_bx, exp_by);
      end
      n_tests++;
      if (sc !== exp_bs) begin
         n_fail++;
         $display("FAIL abort_best_at_stop: got %0d want %0d", sc, exp_bs);
      end
   endtask

   task automatic test_start_busy();
      int dn, bb; bit tmo;
      mode = 0;
      model(1000, 32'hFFFF_FFFF);
      run_sweep(1, dn, bb, tmo);
      n_tests++;
      if (tmo || dn != 1 || bb != 0 || pcnt !== 16'(exp_cnt) || seen_x != exp_x ||
          seen_y != exp_y) begin
         n_fail++;
         $display("FAIL start_busy: got tmo=%0d dones=%0d cnt=%0d npos=%0d want 0/1/%0d/%0d",
                  tmo, dn, pcnt, seen_x.size(), exp_cnt, exp_x.size());
      end
   endtask

   task automatic test_idle_ignore();
      logic [15:0] c0; logic [31:0] s0;
      c0 = pcnt; s0 = bscore;
      poke = 1'b1;
      repeat (4) @(negedge clk);
      poke = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || corr_ready !== 1'b0 || pcnt !== c0 || bscore !== s0) begin
         n_fail++;
         $display("FAIL finished_in_idle: got busy=%b cnt=%0d score=%0d want 0 %0d %0d",
                  busy, pcnt, bscore, c0, s0);
      end
   endtask

   task automatic test_abort_start();
      int b;
      b = 0;
      @(negedge clk); start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      if (busy) b++;
      @(negedge clk);
      if (busy) b++;
      n_tests++;
      if (b != 0) begin
         n_fail++;
         $display("FAIL abort_beats_start: busy cycles got %0d want 0", b);
      end
   endtask

   task automatic test_reset_mid_run();
      bit got;
      got = 0;
      mode = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (pcnt == 16'd2 && corr_ready) begin
            got = 1;
            break;
         end
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (!got || {corr_ready, busy, done, xs, ys, bscore, bx, by, pcnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_run: reached=%0d ready=%b busy=%b cnt=%0d score=%0d x=%0d want 0",
                  got, corr_ready, busy, pcnt, bscore, xs);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

`ifdef CORR_SCHED_THRESH_EN
   task automatic test_thresh();
      int dn, bb; bit tmo;
      logic [31:0] tv [3];
      tv[0] = 32'd16; tv[1] = 32'd20; tv[2] = 32'd1000;
      mode = 0;
      for (int k = 0; k < 3; k++) begin
         thr = tv[k];
         model(1000, tv[k]);
         run_sweep(0, dn, bb, tmo);
         n_tests++;
         if (tmo || dn != 1 || hit !== exp_hit || pcnt !== 16'(exp_cnt) || bscore !== exp_bs ||
             bx !== 13'(exp_bx) || by !== 13'(exp_by)) begin
            n_fail++;
            $display("FAIL thresh_%0d: got hit=%b cnt=%0d %0d@(%0d,%0d) want hit=%b %0d %0d@(%0d,%0d)",
                     tv[k], hit, pcnt, bscore, bx, by, exp_hit, exp_cnt, exp_bs, exp_bx, exp_by);
         end
      end
      n_tests++;
      if (exp_cnt != 6 || hit !== 1'b0) begin
         n_fail++;
         $display("FAIL thresh_clear: got hit=%b want 0 after full sweep", hit);
      end
      thr = '1;
   endtask
`endif

   initial begin
      test_reset();
      test_raster();
      test_ties();
      test_random();
      test_abort();
      test_start_busy();
      test_idle_ignore();
      test_abort_start();
      test_reset_mid_run();
`ifdef CORR_SCHED_THRESH_EN
      test_thresh();
`endif
      test_raster();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
